// File: rtl/cmd_sched_pkg.sv
// -----------------------------------------------------------------------------
// cmd_sched_pkg
//   Shared definitions for the command scheduler:
//     state_t            - scheduler FSM states
//     ACK / NAK / TMO    - response byte codes
//     OPC_MSB / OPC_LSB  - opcode field position inside the 16-bit command word
//     ARG_W              - argument field width (cmd[ARG_W-1:0])
//     opc_valid()        - opcode maps onto an existing engine (1..num_eng)
// -----------------------------------------------------------------------------
package cmd_sched_pkg;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP,
      RESP_WAIT
   } state_t;

   localparam logic [7:0] ACK = 8'hA5;
   localparam logic [7:0] NAK = 8'h5A;
   localparam logic [7:0] TMO = 8'hEE;

   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 12;
   localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;
   localparam int ARG_W   = 12;

   // Opcode 0 is reserved; engines are numbered from 1.
   function automatic logic opc_valid(input logic [OPC_W-1:0] opc, input int num_eng);
      return (opc != '0) && (int'(opc) <= num_eng);
   endfunction

endpackage

// File: rtl/cmd_sched_if.sv
// -----------------------------------------------------------------------------
// cmd_sched_if
//   Bundles the scheduler's command, engine and response signals.
//     cmd / cmd_rdy / clr_cmd_rdy         - command word handshake with the UART wrapper
//     eng_go / eng_arg / eng_done / eng_abort - engine start, argument, completion, abort
//     resp_trmt / resp_tx_data / resp_tx_done - response byte to the transmitter
//     busy                                - scheduler not idle
//   modport slave  : the scheduler side
//   modport master : the environment side (wrapper, engines, transmitter)
// -----------------------------------------------------------------------------
interface cmd_sched_if #(
   parameter int NUM_ENG = 4
);
   import cmd_sched_pkg::*;

   logic [15:0]        cmd;
   logic               cmd_rdy;
   logic               clr_cmd_rdy;
   logic [NUM_ENG-1:0] eng_go;
   logic [ARG_W-1:0]   eng_arg;
   logic [NUM_ENG-1:0] eng_done;
   logic               eng_abort;
   logic               resp_trmt;
   logic [7:0]         resp_tx_data;
   logic               resp_tx_done;
   logic               busy;

   modport slave (
      input  cmd, cmd_rdy, eng_done, resp_tx_done,
      output clr_cmd_rdy, eng_go, eng_arg, eng_abort, resp_trmt, resp_tx_data, busy
   );

   modport master (
      output cmd, cmd_rdy, eng_done, resp_tx_done,
      input  clr_cmd_rdy, eng_go, eng_arg, eng_abort, resp_trmt, resp_tx_data, busy
   );

endinterface

// File: rtl/wdog_timer.sv
// -----------------------------------------------------------------------------
// wdog_timer
//   Execution watchdog. Counts enabled cycles from 0 and flags the last allowed
//   cycle; the count saturates there instead of wrapping.
//   Ports:
//     clk, rst_n - clock, asynchronous active-low reset
//     clr        - force the count back to 0 (has priority over en)
//     en         - count this cycle
//     expired    - count equals TIMEOUT-1
// -----------------------------------------------------------------------------
module wdog_timer #(
   parameter int TIMEOUT = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int            CW   = $clog2(TIMEOUT);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en && !expired)
         cnt <= cnt + CW'(1);
   end

   assign expired = (cnt == LAST);

endmodule

// File: rtl/cmd_sched.sv
// -----------------------------------------------------------------------------
// cmd_sched
//   Takes command words from the UART wrapper, starts the addressed engine,
//   waits for its completion (or aborts it on watchdog expiry) and sends one
//   response byte per consumed command.
//   Ports:
//     clk, rst_n - clock, asynchronous active-low reset
//     bus        - cmd_sched_if.slave (command, engine and response signals)
//   Parameters:
//     NUM_ENG    - number of engines (1..15), opcodes 1..NUM_ENG are valid
//     TIMEOUT    - maximum EXEC residency in cycles (>= 2)
// -----------------------------------------------------------------------------
module cmd_sched
   import cmd_sched_pkg::*;
#(
   parameter int NUM_ENG = 4,
   parameter int TIMEOUT = 1_000_000
) (
   input  logic      clk,
   input  logic      rst_n,
   cmd_sched_if.slave bus
);

   state_t             state;
   logic [15:0]        cmd_q;
   logic [NUM_ENG-1:0] eng_go_q;
   logic               eng_abort_q;
   logic               resp_trmt_q;
   logic [7:0]         resp_data_q;

   logic [OPC_W-1:0]   opc_in;
   logic [OPC_W-1:0]   opc_q;
   logic [NUM_ENG-1:0] go_mask;
   logic [NUM_ENG-1:0] sel_mask;
   logic               done_hit;
   logic               expired;

   assign opc_in = bus.cmd[OPC_MSB:OPC_LSB];
   assign opc_q  = cmd_q[OPC_MSB:OPC_LSB];

   // go_mask decodes the incoming opcode, sel_mask the one being executed.
   always_comb begin
      go_mask  = '0;
      sel_mask = '0;
      for (int i = 0; i < NUM_ENG; i++) begin
         go_mask[i]  = (opc_in == OPC_W'(i + 1));
         sel_mask[i] = (opc_q  == OPC_W'(i + 1));
      end
   end

   // Only the addressed engine's done bit counts.
   assign done_hit = |(bus.eng_done & sel_mask);

   // Counter is held at 0 outside EXEC, so it reads 0 on the first EXEC cycle.
   wdog_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (state != EXEC),
      .en      (state == EXEC),
      .expired (expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cmd_q       <= '0;
         eng_go_q    <= '0;
         eng_abort_q <= 1'b0;
         resp_trmt_q <= 1'b0;
         resp_data_q <= '0;
      end else begin
         eng_go_q    <= '0;
         eng_abort_q <= 1'b0;
         resp_trmt_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.cmd_rdy) begin
                  cmd_q <= bus.cmd;
                  if (opc_valid(opc_in, NUM_ENG)) begin
                     state    <= EXEC;
                     eng_go_q <= go_mask;
                  end else begin
                     state       <= RESP;
                     resp_trmt_q <= 1'b1;
                     resp_data_q <= NAK;
                  end
               end
            end
            EXEC: begin
               // Done is checked first so it wins over a simultaneous expiry.
               if (done_hit) begin
                  state       <= RESP;
                  resp_trmt_q <= 1'b1;
                  resp_data_q <= ACK;
               end else if (expired) begin
                  state       <= RESP;
                  resp_trmt_q <= 1'b1;
                  resp_data_q <= TMO;
                  eng_abort_q <= 1'b1;
               end
            end
            // resp_tx_done seen here still belongs to the previous byte.
            RESP: state <= RESP_WAIT;
            RESP_WAIT: begin
               if (bus.resp_tx_done)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.clr_cmd_rdy  = (state == IDLE) && bus.cmd_rdy;
   assign bus.eng_go       = eng_go_q;
   assign bus.eng_arg      = cmd_q[ARG_W-1:0];
   assign bus.eng_abort    = eng_abort_q;
   assign bus.resp_trmt    = resp_trmt_q;
   assign bus.resp_tx_data = resp_data_q;
   assign bus.busy         = (state != IDLE);

endmodule

// File: doc/cmd_sched.md
CMD_SCHED -- requirements
Module: cmd_sched

Interface
REQ-001 Parameter NUM_ENG, default 4, is the number of execution engines; legal range is 1..15.
REQ-002 Parameter TIMEOUT, default 1_000_000, is the maximum number of EXEC cycles allowed before abort; it must be at least 2.
REQ-003 Port clk, input, 1 bit: system clock; all state changes on posedge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port cmd, input, 16 bits: command word from the UART wrapper; [15:12] is the opcode and [11:0] is the argument.
REQ-006 Port cmd_rdy, input, 1 bit: a command word is valid and pending.
REQ-007 Port clr_cmd_rdy, output, 1 bit: consume pulse back to the wrapper.
REQ-008 Port eng_go, output, NUM_ENG bits: one-hot, one-cycle start pulse per engine.
REQ-009 Port eng_arg, output, 12 bits: latched argument for the active engine.
REQ-010 Port eng_done, input, NUM_ENG bits: completion pulse or level per engine.
REQ-011 Port eng_abort, output, 1 bit: one-cycle abort pulse on timeout.
REQ-012 Port resp_trmt, output, 1 bit: start transmission of a response byte.
REQ-013 Port resp_tx_data, output, 8 bits: response byte.
REQ-014 Port resp_tx_done, input, 1 bit: transmitter-done level; it stays high until the next resp_trmt.
REQ-015 Port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-016 States: IDLE, EXEC, RESP and RESP_WAIT; transitions occur only as stated below.
REQ-017 In IDLE with cmd_rdy=1, cmd_sched shall assert clr_cmd_rdy combinationally in that same cycle and latch cmd.
- If the opcode is in 1..NUM_ENG, the next state is EXEC.
- Otherwise, the next state is RESP with code NAK.
REQ-018 clr_cmd_rdy shall be 0 in every other state; a cmd_rdy arriving while busy stays pending and is consumed on the first IDLE cycle.
REQ-019 In the first EXEC cycle, eng_go[opcode-1] shall be 1 for exactly one cycle; all other eng_go bits shall stay 0.
REQ-020 eng_arg shall equal the latched cmd[11:0] from EXEC entry until the next command is latched.
REQ-021 In EXEC, the timeout counter shall start at 0 on entry and increment each cycle.
- eng_done[opcode-1]=1 shall select next state RESP with code ACK.
- eng_done bits for other engines shall be ignored.
REQ-022 When the counter reaches TIMEOUT-1 and done is absent, cmd_sched shall pulse eng_abort for one cycle and select RESP with code TMO.
REQ-023 If done and timeout expiry occur in the same cycle, done shall win: ACK is sent and eng_abort is not pulsed.
REQ-024 eng_done asserted in the eng_go cycle shall count as completion, giving a minimum EXEC residency of 1 cycle.
REQ-025 In RESP, resp_trmt shall be 1 for exactly one cycle, with resp_tx_data holding the code; the next state is RESP_WAIT.
REQ-026 resp_tx_data shall hold its value from RESP until the next RESP.
REQ-027 In RESP_WAIT, resp_tx_done=1 shall return the state to IDLE.
- resp_tx_done sampled during the RESP cycle itself is stale and shall be ignored.
REQ-028 Response codes: ACK = 8'hA5, NAK = 8'h5A, TMO = 8'hEE.
REQ-029 Exactly one response byte shall be sent per consumed command.
REQ-030 Counter width shall be $clog2(TIMEOUT); the counter shall not wrap while in EXEC.

Reset
REQ-031 On rst_n low, outputs shall be:
- state = IDLE, with the timeout counter, latched cmd, eng_arg and resp_tx_data at 0.
- clr_cmd_rdy, eng_go, eng_abort, resp_trmt and busy at 0.
REQ-032 A reset taken in EXEC shall not pulse eng_abort, and no response byte shall be sent for the interrupted command.

Structure
REQ-033 Package cmd_sched_pkg shall hold:
- the state enum;
- the ACK, NAK and TMO localparams;
- the OPC_MSB/OPC_LSB/ARG_W field constants.
REQ-034 The timeout counter shall be a single sub-module, wdog_timer, with inputs clr and en and output expired.
REQ-035 eng_go, eng_abort and resp_trmt shall be registered outputs; clr_cmd_rdy is the only combinational output.

Verification
REQ-036 Scenario 1: cmd=16'h2ABC with cmd_rdy; eng_done[1] 5 cycles after eng_go -> clr_cmd_rdy in the cmd_rdy cycle, eng_go=4'b0010 once, eng_arg=12'hABC, one resp_trmt with 8'hA5, then IDLE after resp_tx_done.
REQ-037 Scenario 2: cmd=16'h9000 with NUM_ENG=4 -> no eng_go, resp_trmt with 8'h5A, busy until resp_tx_done.
REQ-038 Scenario 3: TIMEOUT=16, cmd=16'h1001, no done -> eng_abort exactly 16 cycles after EXEC entry, then resp byte 8'hEE.
REQ-039 Scenario 4: TIMEOUT=16 with eng_done[0] on the expiry cycle -> no eng_abort, resp byte 8'hA5.
REQ-040 Scenario 5: second cmd_rdy raised during EXEC; resp_tx_done held high from the prior byte -> second command not consumed until IDLE, and RESP_WAIT not exited in the resp_trmt cycle.
REQ-041 Scenario 6: rst_n low mid-EXEC -> all outputs 0 asynchronously, no eng_abort and no resp_trmt; the next command is processed normally.
